// File: rtl/mc_pkg.sv
// Shared types and instruction-field constants for the mc_core multi-cycle datapath.
package mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LDI = 3'b100,
    OP_LW  = 3'b101,
    OP_SW  = 3'b110,
    OP_BNZ = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int IR_W   = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RA_MSB = 5;
  localparam int RA_LSB = 3;
  localparam int RB_MSB = 2;
  localparam int RB_LSB = 0;

  // BNZ carrying this immediate stops the core instead of branching.
  localparam logic [2:0] OP_HALT_IMM = 3'd0;

endpackage

// File: rtl/mc_if.sv
// Instruction-ROM and data-memory bus of mc_core.
// Data handshake: the core raises dmem_req with dmem_we/addr/wdata and holds them
// unchanged until it samples dmem_ready = 1 on a rising edge; that edge completes
// the transfer (dmem_rdata is captured for a load), and dmem_req drops the next cycle.
interface mc_if #(
  parameter int DW = 8,
  parameter int PW = 10
);
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ready;

  modport master (
    output imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_data, dmem_rdata, dmem_ready
  );

  modport slave (
    input  imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_data, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one clocked write port, async clear.
module mc_regfile #(
  parameter int DW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [RW-1:0] raddr_a,
  input  logic [RW-1:0] raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);
  logic [DW-1:0] regs [2**RW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**RW; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads see the value before this cycle's write, so ra = rb uses the old value.
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/mc_core.sv
// Multi-cycle core: FETCH/EXEC/MEM sequencing over a ROM, a register file and a
// stallable data memory, with start/done control and a saturating cycle counter.
module mc_core
  import mc_pkg::*;
#(
  parameter int DW = 8,
  parameter int PW = 10,
  parameter int RW = 3,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [CW-1:0] cycles,
  output state_t        dbg_state,
  mc_if.master          bus
);
  state_t            state, state_n;
  logic [PW-1:0]     pc, pc_n;
  logic [IR_W-1:0]   ir;
  logic              ir_load;
  op_t               op;
  logic [RW-1:0]     ra_idx, rb_idx;
  logic [2:0]        imm;
  logic [DW-1:0]     ra_val, rb_val, alu_y;
  logic              rf_we;
  logic [DW-1:0]     rf_wdata;
  logic              mem_go, mem_fin;
  logic              req_r, we_r;
  logic [DW-1:0]     addr_r, wdata_r;

  assign op     = op_t'(ir[OP_MSB:OP_LSB]);
  assign ra_idx = RW'(ir[RA_MSB:RA_LSB]);
  assign rb_idx = RW'(ir[RB_MSB:RB_LSB]);
  assign imm    = ir[RB_MSB:RB_LSB];

  mc_regfile #(.DW(DW), .RW(RW)) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .we      (rf_we),
    .waddr   (ra_idx),
    .wdata   (rf_wdata),
    .raddr_a (ra_idx),
    .raddr_b (rb_idx),
    .rdata_a (ra_val),
    .rdata_b (rb_val)
  );

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:  alu_y = ra_val + rb_val;
      OP_SUB:  alu_y = ra_val - rb_val;
      OP_AND:  alu_y = ra_val & rb_val;
      OP_XOR:  alu_y = ra_val ^ rb_val;
      OP_LDI:  alu_y = DW'(imm);
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = alu_y;
    mem_go   = 1'b0;
    mem_fin  = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n = S_FETCH;
          pc_n    = '0;
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW: begin
            mem_go  = 1'b1;
            state_n = S_MEM;
          end
          OP_BNZ: begin
            if (imm == OP_HALT_IMM) begin
              state_n = S_HALT;
            end else begin
              state_n = S_FETCH;
              pc_n    = (ra_val != '0) ? pc - PW'(imm) : pc + PW'(1);
            end
          end
          default: begin
            rf_we   = 1'b1;
            pc_n    = pc + PW'(1);
            state_n = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          mem_fin  = 1'b1;
          rf_we    = (op == OP_LW);
          rf_wdata = bus.dmem_rdata;
          pc_n     = pc + PW'(1);
          state_n  = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (ir_load) ir <= bus.imem_data;
    end
  end

  // Counts every cycle spent executing; a new start restarts it from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycles <= '0;
    end else if (state == S_IDLE || state == S_HALT) begin
      if (start) cycles <= '0;
    end else if (cycles != {CW{1'b1}}) begin
      cycles <= cycles + CW'(1);
    end
  end

  // Request fields are captured once in EXEC so they stay frozen through stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (mem_go) begin
      req_r   <= 1'b1;
      we_r    <= (op == OP_SW);
      addr_r  <= rb_val;
      wdata_r <= ra_val;
    end else if (mem_fin) begin
      req_r   <= 1'b0;
      we_r    <= 1'b0;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.dmem_req   = req_r;
  assign bus.dmem_we    = we_r;
  assign bus.dmem_addr  = addr_r;
  assign bus.dmem_wdata = wdata_r;
  assign done           = (state == S_HALT);
  assign dbg_state      = state;
endmodule

// File: tb/tb_mc_core.sv
// Randomised and directed programs for mc_core, checked against an instruction-level model.
module tb_mc_core;
  import mc_pkg::*;

  localparam int DW = 8;
  localparam int PW = 10;
  localparam int RW = 3;
  localparam int CW = 6;
  localparam int MAX_STEPS = 300;
  localparam int BUDGET = 4000;
  localparam logic [8:0] HALT_W = 9'h1C0;

  logic          clk, reset, start, done;
  logic [CW-1:0] cycles;
  state_t        dbg_state;

  mc_if #(.DW(DW), .PW(PW)) bus ();

  mc_core #(.DW(DW), .PW(PW), .RW(RW), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .cycles    (cycles),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus state ----------------
  logic [8:0]    rom [1024];
  logic [DW-1:0] tb_mem [256];
  int            stall_arr [512];
  int            txn_idx = 0;
  int            rsp_cnt = 0;

  assign bus.imem_data = rom[bus.imem_addr];

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_reg [8];
  logic [DW-1:0] m_mem [256];
  logic [DW-1:0] s_reg [8];
  logic [DW-1:0] s_mem [256];

  // ---------------- scoreboard ----------------
  logic [PW-1:0]      exp_pc_q[$];
  logic [16:0]        exp_mem_q[$];
  logic [CW+PW-1:0]   exp_done_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input op_t op, input int a, input int b);
    return {op, 3'(a), 3'(b)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = HALT_W;
  endtask

  task automatic fill_stalls();
    for (int i = 0; i < 512; i++) stall_arr[i] = $urandom_range(0, 3);
  endtask

  task automatic flush_q();
    exp_pc_q.delete();
    exp_mem_q.delete();
    exp_done_q.delete();
  endtask

  // Instruction-set interpreter: walks the ROM, predicts fetch order, memory
  // transactions, final PC and the saturated cycle count.
  task automatic run_model(output bit halted);
    int pc, cyc, si, sat;
    logic [8:0] ins;
    logic [2:0] a, b;
    logic [DW-1:0] ad;
    pc = 0; cyc = 0; si = txn_idx; halted = 1'b0;
    for (int steps = 0; steps < MAX_STEPS && !halted; steps++) begin
      ins = rom[pc];
      a = ins[5:3];
      b = ins[2:0];
      exp_pc_q.push_back(PW'(pc));
      case (ins[8:6])
        3'd0: begin m_reg[a] = m_reg[a] + m_reg[b]; pc = pc + 1; cyc += 2; end
        3'd1: begin m_reg[a] = m_reg[a] - m_reg[b]; pc = pc + 1; cyc += 2; end
        3'd2: begin m_reg[a] = m_reg[a] & m_reg[b]; pc = pc + 1; cyc += 2; end
        3'd3: begin m_reg[a] = m_reg[a] ^ m_reg[b]; pc = pc + 1; cyc += 2; end
        3'd4: begin m_reg[a] = DW'(b); pc = pc + 1; cyc += 2; end
        3'd5: begin
          ad = m_reg[b];
          exp_mem_q.push_back({1'b0, ad, 8'h00});
          m_reg[a] = m_mem[ad];
          cyc += 3 + stall_arr[si % 512]; si++; pc = pc + 1;
        end
        3'd6: begin
          ad = m_reg[b];
          exp_mem_q.push_back({1'b1, ad, m_reg[a]});
          m_mem[ad] = m_reg[a];
          cyc += 3 + stall_arr[si % 512]; si++; pc = pc + 1;
        end
        default: begin
          cyc += 2;
          if (b == 3'd0) halted = 1'b1;
          else if (m_reg[a] != '0) pc = pc - int'(b);
          else pc = pc + 1;
        end
      endcase
      pc = (pc + 1024) % 1024;
    end
    sat = (cyc > 2**CW - 1) ? 2**CW - 1 : cyc;
    if (halted) exp_done_q.push_back({CW'(sat), PW'(pc)});
  endtask

  // ---------------- memory responder (drives away from the active edge) ----------------
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      bus.dmem_ready = 1'b0;
      rsp_cnt = 0;
    end else if (bus.dmem_req) begin
      bus.dmem_rdata = tb_mem[bus.dmem_addr];
      if (rsp_cnt >= stall_arr[txn_idx % 512]) begin
        bus.dmem_ready = 1'b1;
        if (bus.dmem_we) tb_mem[bus.dmem_addr] = bus.dmem_wdata;
        txn_idx++;
      end else begin
        bus.dmem_ready = 1'b0;
        rsp_cnt++;
      end
    end else begin
      bus.dmem_ready = 1'($urandom_range(0, 1));
      bus.dmem_rdata = DW'($urandom);
      rsp_cnt = 0;
    end
  end

  // ---------------- monitor ----------------
  logic          p_req = 1'b0, p_ready = 1'b0, p_we = 1'b0, p_done = 1'b0;
  logic [DW-1:0] p_addr = '0, p_wdata = '0;

  always @(negedge clk) begin
    logic [16:0]      em;
    logic [CW+PW-1:0] ed;
    if (mon_en && reset) begin
      if (dbg_state == S_FETCH) begin
        if (exp_pc_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pc_trace: unexpected fetch at pc 0x%0h", bus.imem_addr);
        end else begin
          check("pc_trace", 32'(bus.imem_addr), 32'(exp_pc_q.pop_front()));
        end
      end
      if (bus.dmem_req && p_req && !p_ready) begin
        check("stall_we",    32'(bus.dmem_we),    32'(p_we));
        check("stall_addr",  32'(bus.dmem_addr),  32'(p_addr));
        check("stall_wdata", 32'(bus.dmem_wdata), 32'(p_wdata));
      end
      if (bus.dmem_req && bus.dmem_ready) begin
        if (exp_mem_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL mem_txn: unexpected request addr 0x%0h", bus.dmem_addr);
        end else begin
          em = exp_mem_q.pop_front();
          check("mem_we",   32'(bus.dmem_we),   32'(em[16]));
          check("mem_addr", 32'(bus.dmem_addr), 32'(em[15:8]));
          if (em[16]) check("mem_wdata", 32'(bus.dmem_wdata), 32'(em[7:0]));
        end
      end
      if (done && !p_done) begin
        if (exp_done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL halt: unexpected done at pc 0x%0h", bus.imem_addr);
        end else begin
          ed = exp_done_q.pop_front();
          check("halt_cycles", 32'(cycles),        32'(ed[CW+PW-1:PW]));
          check("halt_pc",     32'(bus.imem_addr), 32'(ed[PW-1:0]));
        end
      end
    end
    p_req = bus.dmem_req; p_ready = bus.dmem_ready; p_we = bus.dmem_we;
    p_addr = bus.dmem_addr; p_wdata = bus.dmem_wdata; p_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic exec_prog(output int lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < BUDGET) begin
      start = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done after %0d cycles, state %0d", lat, dbg_state);
    end
    @(negedge clk);
    check("pc_q_drained",   32'(exp_pc_q.size()),   32'd0);
    check("mem_q_drained",  32'(exp_mem_q.size()),  32'd0);
    check("done_q_drained", 32'(exp_done_q.size()), 32'd0);
    flush_q();
  endtask

  task automatic run_directed(output int lat);
    bit ok;
    run_model(ok);
    exec_prog(lat);
  endtask

  task automatic dump_regs();
    int lat;
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = enc(OP_SW, i, 0);
    fill_stalls();
    run_directed(lat);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_done"},   32'(done),           32'd0);
    check({tag, "_iaddr"},  32'(bus.imem_addr),  32'd0);
    check({tag, "_req"},    32'(bus.dmem_req),   32'd0);
    check({tag, "_we"},     32'(bus.dmem_we),    32'd0);
    check({tag, "_daddr"},  32'(bus.dmem_addr),  32'd0);
    check({tag, "_wdata"},  32'(bus.dmem_wdata), 32'd0);
    check({tag, "_cycles"}, 32'(cycles),         32'd0);
    check({tag, "_state"},  32'(dbg_state),      32'(S_IDLE));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, n;
    bit ok;
    logic [2:0] rop;
    reset = 1'b0;
    start = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = DW'($urandom);
      m_mem[i]  = tb_mem[i];
    end
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    clear_rom();
    fill_stalls();

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // LDI r1,5; LDI r2,3; ADD r1,r2; HALT
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 5);
    rom[1] = enc(OP_LDI, 2, 3);
    rom[2] = enc(OP_ADD, 1, 2);
    run_directed(lat);
    check("add_prog_latency", 32'(lat), 32'd8);
    check("add_prog_cycles",  32'(cycles), 32'd8);
    dump_regs();

    // Countdown loop: body at PC 2..3 runs twice.
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 2);
    rom[1] = enc(OP_LDI, 3, 1);
    rom[2] = enc(OP_SUB, 1, 3);
    rom[3] = enc(OP_BNZ, 1, 1);
    run_directed(lat);
    check("loop_latency", 32'(lat), 32'd14);
    dump_regs();

    // Build 0x5A in r1, r2 = 7, store with three stall cycles.
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 5);
    rom[1] = enc(OP_LDI, 3, 5);
    rom[2] = enc(OP_ADD, 1, 1);
    rom[3] = enc(OP_ADD, 1, 1);
    rom[4] = enc(OP_ADD, 1, 1);
    rom[5] = enc(OP_ADD, 1, 3);
    rom[6] = enc(OP_ADD, 1, 1);
    rom[7] = enc(OP_LDI, 2, 7);
    rom[8] = enc(OP_SW, 1, 2);
    fill_stalls();
    stall_arr[txn_idx % 512] = 3;
    run_directed(lat);
    check("sw_stall_latency", 32'(lat), 32'(8 * 2 + 3 + 3 + 2));
    check("sw_stall_mem7",    32'(tb_mem[7]), 32'h5A);

    // Load 0xC3 with ready on the first MEM cycle, then store it back to expose r4.
    tb_mem[7] = 8'hC3;
    m_mem[7]  = 8'hC3;
    clear_rom();
    rom[0] = enc(OP_LW, 4, 2);
    rom[1] = enc(OP_SW, 4, 0);
    fill_stalls();
    stall_arr[txn_idx % 512] = 0;
    run_directed(lat);
    dump_regs();

    // r1 = 0xFF, then backward branch from PC 1 wraps to 1022 where 0xFF + 1 = 0.
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 0);
    rom[1] = enc(OP_LDI, 3, 1);
    rom[2] = enc(OP_SUB, 1, 3);
    rom[3] = enc(OP_SW, 1, 3);
    fill_stalls();
    run_directed(lat);
    clear_rom();
    rom[0]    = enc(OP_LDI, 3, 1);
    rom[1]    = enc(OP_BNZ, 3, 3);
    rom[1022] = enc(OP_ADD, 1, 3);
    run_directed(lat);
    dump_regs();

    // 64 execution cycles: one past the 6-bit counter's maximum.
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 7);
    rom[1] = enc(OP_ADD, 1, 1);
    rom[2] = enc(OP_LDI, 3, 1);
    rom[3] = enc(OP_SUB, 1, 3);
    rom[4] = enc(OP_BNZ, 1, 1);
    run_directed(lat);
    check("sat_latency", 32'(lat), 32'd64);
    check("sat_cycles",  32'(cycles), 32'd63);

    // Asynchronous reset while a store is stalled in MEM.
    mon_en = 1'b0;
    clear_rom();
    rom[0] = enc(OP_LDI, 1, 5);
    rom[1] = enc(OP_SW, 1, 1);
    fill_stalls();
    stall_arr[txn_idx % 512] = 1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dbg_state != S_MEM && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_mem", 32'(dbg_state), 32'(S_MEM));
    @(negedge clk);
    check("rst_req_before", 32'(bus.dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1 check_outputs_zero("rst_async");
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("rst_held");
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    check("rst_mem5_unwritten", 32'(tb_mem[5]), 32'(m_mem[5]));
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    mon_en = 1'b1;
    @(negedge clk);
    dump_regs();

    // Random programs; ones that fail to halt within the step bound are redrawn.
    for (int p = 0; p < 20; p++) begin
      do begin
        clear_rom();
        for (int k = 0; k < 10; k++) begin
          rop = 3'($urandom_range(0, 7));
          rom[k] = {rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
        end
        fill_stalls();
        s_reg = m_reg;
        s_mem = m_mem;
        run_model(ok);
        if (!ok) begin
          m_reg = s_reg;
          m_mem = s_mem;
          flush_q();
        end
      end while (!ok);
      exec_prog(lat);
      if (p % 5 == 4) dump_regs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
